// File: rtl/star_pkg.sv
// rtl/star_pkg.sv - star state codes, scheduler state encoding and lane mapping
package star_pkg;

  typedef enum logic [2:0] {
    STAR_HIDE   = 3'd0,
    STAR_UP_A   = 3'd1,
    STAR_DOWN_A = 3'd2,
    STAR_DOWN_B = 3'd5,
    STAR_UP_B   = 3'd6
  } star_code_e;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_RUN   = 2'd1,
    SCHED_PAUSE = 2'd2
  } sched_state_e;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic star_code_e lane_to_code(input logic [1:0] lane);
    case (lane)
      2'b00:   return STAR_UP_A;
      2'b01:   return STAR_DOWN_A;
      2'b10:   return STAR_DOWN_B;
      default: return STAR_UP_B;
    endcase
  endfunction

endpackage

// File: rtl/star_scheduler_if.sv
// rtl/star_scheduler_if.sv - game-control inputs and per-slot star outputs of the scheduler
interface star_scheduler_if #(
  parameter int NUM_STARS = 4
);
  logic                   tick;
  logic                   start;
  logic                   pause;
  logic                   game_over;
  logic [2:0]             level;
  logic [3*NUM_STARS-1:0] star_state;
  logic [NUM_STARS-1:0]   star_restart;
  logic [NUM_STARS-1:0]   active_mask;
  logic                   spawn_missed;
  logic [15:0]            spawn_count;
  logic [1:0]             sched_state;

  modport master (
    output tick, start, pause, game_over, level,
    input  star_state, star_restart, active_mask, spawn_missed, spawn_count, sched_state
  );

  modport slave (
    input  tick, start, pause, game_over, level,
    output star_state, star_restart, active_mask, spawn_missed, spawn_count, sched_state
  );
endinterface

// File: rtl/star_lfsr.sv
// rtl/star_lfsr.sv - 16-bit right-shifting Galois LFSR with step enable
module star_lfsr
  import star_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_i,
  output logic [15:0] value_o
);
  // An all-zero seed would lock the register, so it is replaced
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;
endmodule

// File: rtl/star_scheduler.sv
// rtl/star_scheduler.sv - paces star spawns on the frame tick and retires them after their lifetime
module star_scheduler
  import star_pkg::*;
#(
  parameter int          NUM_STARS     = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          BASE_INTERVAL = 120,
  parameter int          LEVEL_STEP    = 15,
  parameter int          MIN_INTERVAL  = 30,
  parameter int          LIFETIME      = 850
) (
  input  logic            clk,
  input  logic            rst,
  star_scheduler_if.slave bus
);
  sched_state_e         state_q, state_d;
  logic [10:0]          ic_q, ic_d;
  logic [15:0]          count_q, count_d;
  logic                 missed_q, missed_d;
  logic [15:0]          lfsr_val;
  logic                 unused_lfsr_bits;
  logic [10:0]          level_step, interval;
  logic                 run_tick, spawn_due, any_free;
  logic [NUM_STARS-1:0] free_onehot, mask_vec;
  star_code_e           lane_code;

  always_comb begin
    state_d = state_q;
    if (bus.game_over) begin
      state_d = SCHED_IDLE;
    end else begin
      case (state_q)
        SCHED_IDLE:  if (bus.start && !bus.pause) state_d = SCHED_RUN;
        SCHED_RUN:   if (bus.pause) state_d = SCHED_PAUSE;
        SCHED_PAUSE: if (!bus.pause) state_d = SCHED_RUN;
        default:     state_d = SCHED_IDLE;
      endcase
    end
  end

  assign run_tick = (state_q == SCHED_RUN) && bus.tick && !bus.pause && !bus.game_over;

  // Subtraction would wrap for high levels, so the floor is checked explicitly
  always_comb begin
    level_step = 11'(LEVEL_STEP) * 11'(bus.level);
    if ((level_step >= 11'(BASE_INTERVAL)) ||
        ((11'(BASE_INTERVAL) - level_step) < 11'(MIN_INTERVAL))) begin
      interval = 11'(MIN_INTERVAL);
    end else begin
      interval = 11'(BASE_INTERVAL) - level_step;
    end
  end

  // A level increase can leave ic beyond the new interval; that counts as due
  assign spawn_due = run_tick && (ic_q >= (interval - 11'd1));

  always_comb begin
    free_onehot = '0;
    any_free    = 1'b0;
    for (int i = 0; i < NUM_STARS; i++) begin
      if (!mask_vec[i] && !any_free) begin
        free_onehot[i] = 1'b1;
        any_free       = 1'b1;
      end
    end
  end

  always_comb begin
    ic_d     = ic_q;
    count_d  = count_q;
    missed_d = spawn_due && !any_free;
    if (bus.game_over) begin
      ic_d = '0;
    end else if (run_tick) begin
      ic_d = spawn_due ? 11'd0 : ic_q + 11'd1;
      if (spawn_due && any_free && (count_q != 16'hFFFF)) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SCHED_IDLE;
      ic_q     <= '0;
      count_q  <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ic_q     <= ic_d;
      count_q  <= count_d;
      missed_q <= missed_d;
    end
  end

  star_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step_i  (run_tick),
    .value_o (lfsr_val)
  );

  assign lane_code        = lane_to_code(lfsr_val[1:0]);
  assign unused_lfsr_bits = ^lfsr_val[15:2];

  for (genvar g = 0; g < NUM_STARS; g++) begin : g_slot
    logic [9:0] life_q, life_d;
    star_code_e code_q, code_d;
    logic       act_q, act_d;
    logic       restart_q, restart_d;

    always_comb begin
      life_d    = life_q;
      code_d    = code_q;
      act_d     = act_q;
      restart_d = 1'b0;
      if (bus.game_over) begin
        life_d = '0;
        code_d = STAR_HIDE;
        act_d  = 1'b0;
      end else if (run_tick) begin
        if (spawn_due && free_onehot[g]) begin
          life_d    = 10'(LIFETIME - 1);
          code_d    = lane_code;
          act_d     = 1'b1;
          restart_d = 1'b1;
        end else if (act_q) begin
          if (life_q == '0) begin
            code_d = STAR_HIDE;
            act_d  = 1'b0;
          end else begin
            life_d = life_q - 10'd1;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        life_q    <= '0;
        code_q    <= STAR_HIDE;
        act_q     <= 1'b0;
        restart_q <= 1'b0;
      end else begin
        life_q    <= life_d;
        code_q    <= code_d;
        act_q     <= act_d;
        restart_q <= restart_d;
      end
    end

    assign bus.star_state[3*g +: 3] = code_q;
    assign bus.star_restart[g]      = restart_q;
    assign mask_vec[g]              = act_q;
  end

  assign bus.active_mask  = mask_vec;
  assign bus.spawn_missed = missed_q;
  assign bus.spawn_count  = count_q;
  assign bus.sched_state  = state_q;
endmodule

// File: tb/tb_star_scheduler.sv
// tb/tb_star_scheduler.sv - scoreboard bench for star_scheduler
module tb_star_scheduler;
  import star_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0]   restart;
    logic           missed;
    logic [3*N-1:0] st;
    logic [N-1:0]   mask;
    logic [15:0]    cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  star_scheduler_if #(.NUM_STARS(N)) bus ();

  star_scheduler #(.NUM_STARS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;

  logic [15:0] m_lfsr;
  int          m_ic;
  int          m_cnt;
  int          m_state;
  int          m_life[N];
  bit          m_act[N];
  logic [2:0]  m_st[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3*N-1:0] m_vec();
    logic [3*N-1:0] v;
    for (int i = 0; i < N; i++) v[3*i +: 3] = m_st[i];
    return v;
  endfunction

  function automatic logic [N-1:0] m_maskf();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic model_reset(input bit full);
    m_ic    = 0;
    m_state = 0;
    for (int i = 0; i < N; i++) begin
      m_life[i] = 0;
      m_act[i]  = 1'b0;
      m_st[i]   = 3'd0;
    end
    if (full) begin
      m_lfsr = 16'hACE1;
      m_cnt  = 0;
    end
  endtask

  task automatic model_tick();
    int         iv;
    int         free;
    bit         due;
    logic [2:0] lane;
    ev_t        e;
    if (m_state != 1) return;
    iv = 120 - 15 * int'(bus.level);
    if (iv < 30) iv = 30;
    case (m_lfsr[1:0])
      2'b00:   lane = 3'd1;
      2'b01:   lane = 3'd2;
      2'b10:   lane = 3'd5;
      default: lane = 3'd6;
    endcase
    due  = (m_ic >= iv - 1);
    m_ic = due ? 0 : m_ic + 1;
    free = -1;
    for (int i = 0; i < N; i++) if (!m_act[i] && free < 0) free = i;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (m_life[i] == 0) begin
          m_act[i] = 1'b0;
          m_st[i]  = 3'd0;
        end else begin
          m_life[i]--;
        end
      end
    end
    if (due) begin
      e.restart = '0;
      e.missed  = 1'b0;
      if (free >= 0) begin
        m_act[free]  = 1'b1;
        m_st[free]   = lane;
        m_life[free] = 849;
        if (m_cnt < 65535) m_cnt++;
        e.restart[free] = 1'b1;
      end else begin
        e.missed = 1'b1;
      end
      e.st   = m_vec();
      e.mask = m_maskf();
      e.cnt  = 16'(m_cnt);
      exp_q.push_back(e);
    end
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.tick = 1'b1;
      model_tick();
      @(posedge clk); #1;
      bus.tick = 1'b0;
    end
  endtask

  task automatic do_start(input bit with_tick);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.tick  = with_tick;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    m_state   = 1;
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_sched"}, 64'(bus.sched_state), 64'(m_state));
    check({tag, "_state"}, 64'(bus.star_state), 64'(m_vec()));
    check({tag, "_mask"}, 64'(bus.active_mask), 64'(m_maskf()));
    check({tag, "_count"}, 64'(bus.spawn_count), 64'(m_cnt));
  endtask

  always @(negedge clk) begin
    if (rst && ((|bus.star_restart) || bus.spawn_missed)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: restart=%b missed=%b, required no event",
                 bus.star_restart, bus.spawn_missed);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_restart", 64'(bus.star_restart), 64'(mon_e.restart));
        check("ev_missed", 64'(bus.spawn_missed), 64'(mon_e.missed));
        check("ev_state", 64'(bus.star_state), 64'(mon_e.st));
        check("ev_mask", 64'(bus.active_mask), 64'(mon_e.mask));
        check("ev_count", 64'(bus.spawn_count), 64'(mon_e.cnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick      = 1'b0;
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    bus.game_over = 1'b0;
    bus.level     = 3'd0;
    model_reset(1'b1);

    // Reset held with ticks toggling
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 bus.tick = 1'b1;
      @(posedge clk); #1 bus.tick = 1'b0;
    end
    @(negedge clk);
    check("rst_sched", 64'(bus.sched_state), 64'd0);
    check("rst_state", 64'(bus.star_state), 64'd0);
    check("rst_restart", 64'(bus.star_restart), 64'd0);
    check("rst_mask", 64'(bus.active_mask), 64'd0);
    check("rst_missed", 64'(bus.spawn_missed), 64'd0);
    check("rst_count", 64'(bus.spawn_count), 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    do_ticks(10);
    check_status("idle_no_start");

    // Start with a coincident tick; counting begins on the next tick
    do_start(1'b1);
    do_ticks(119);
    check_status("before_first");
    check("no_spawn_119", 64'(bus.spawn_count), 64'd0);
    do_ticks(1);
    check_status("first_spawn");
    check("first_count", 64'(bus.spawn_count), 64'd1);

    // Level 0 -> 7 with ic at 100 spawns on the next tick
    do_ticks(100);
    bus.level = 3'd7;
    do_ticks(1);
    check_status("level_jump");
    check("jump_count", 64'(bus.spawn_count), 64'd2);

    // Fill remaining slots, then a missed spawn
    do_ticks(90);
    check_status("saturated");
    check("mask_full", 64'(bus.active_mask), 64'hF);

    // Pause for 500 ticks: nothing moves
    @(posedge clk); #1 bus.pause = 1'b1;
    m_state = 2;
    repeat (3) @(posedge clk);
    #1;
    check_status("pause_enter");
    do_ticks(500);
    check_status("pause_end");
    @(posedge clk); #1 bus.pause = 1'b0;
    m_state = 1;
    repeat (3) @(posedge clk);
    #1;
    check_status("resume");

    // Run past slot 0 retirement and reuse
    do_ticks(880);
    check_status("reuse");

    // game_over with a coincident tick clears slots, keeps count
    @(posedge clk); #1;
    bus.game_over = 1'b1;
    bus.tick      = 1'b1;
    @(posedge clk); #1;
    bus.game_over = 1'b0;
    bus.tick      = 1'b0;
    model_reset(1'b0);
    check_status("game_over");

    // Level 5 interval
    bus.level = 3'd5;
    do_start(1'b0);
    do_ticks(44);
    check_status("lvl5_44");
    do_ticks(46);
    check_status("lvl5_90");

    // Asynchronous reset between clock edges
    do_ticks(20);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("arst_count", 64'(bus.spawn_count), 64'd0);
    check("arst_sched", 64'(bus.sched_state), 64'd0);
    check("arst_mask", 64'(bus.active_mask), 64'd0);
    check("arst_restart", 64'(bus.star_restart), 64'd0);
    model_reset(1'b1);
    @(posedge clk); #1 rst = 1'b1;

    // After reset the LFSR restarts from the seed
    bus.level = 3'd0;
    do_start(1'b0);
    do_ticks(120);
    check_status("post_reset_spawn");

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/star_scheduler.md
# star_scheduler

Spawns and retires obstacle stars for the game core. It owns up to NUM_STARS star slots and drives each slot's 3-bit star_state and a restart pulse into that slot's star_loc instance. Spawns are paced on the frame tick by a level-dependent interval, and each new star's lane is picked by an LFSR. It sits between the game-control FSM (start/pause/game_over/level) and the per-star location blocks.

## Interface
- NUM_STARS, 4, number of star slots (1–8)
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001
- BASE_INTERVAL, 120, spawn interval in ticks at level 0
- LEVEL_STEP, 15, interval reduction per level
- MIN_INTERVAL, 30, interval floor in ticks
- LIFETIME, 850, ticks a star stays active (1–1023)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- tick  in  1  one-cycle frame pulse
- start  in  1  IDLE→RUN request
- pause  in  1  level-sensitive hold
- game_over  in  1  clear all, return to IDLE
- level  in  3  difficulty 0–7
- star_state  out  3*NUM_STARS  per-slot state; slot i at [3i+2:3i]
- star_restart  out  NUM_STARS  one-cycle pulse when slot i spawns; reloads star_loc position
- active_mask  out  NUM_STARS  1 = slot occupied
- spawn_missed  out  1  one-cycle pulse: spawn due, no free slot
- spawn_count  out  16  total spawns since reset; saturates at 16'hFFFF
- sched_state  out  2  0 IDLE, 1 RUN, 2 PAUSE

## Operation
- Star state codes: 0 hide, 1 up, 2 down, 5 down, 6 up. No other values are driven.
- FSM transitions:
  - IDLE→RUN on start.
  - RUN→PAUSE while pause=1.
  - PAUSE→RUN when pause=0.
  - Any state→IDLE on game_over.
  - Priority: game_over > pause > start. start is ignored outside IDLE.
- On entry to IDLE, all slots go to hide, active_mask=0, and life/interval counters clear. The LFSR and spawn_count are kept.
- interval = max(BASE_INTERVAL − LEVEL_STEP·level, MIN_INTERVAL). Compute in 11-bit unsigned so a negative result clamps; level 6 and 7 give 30, level 5 gives 45. level is sampled on every tick, so a change takes effect on the next comparison.
- Interval counter (11 bits), on each RUN tick:
  - If ic == interval−1: ic←0 and a spawn is due.
  - Otherwise ic←ic+1.
  - If level rises so that ic ≥ interval, treat it as equal: spawn due, ic←0.
- LFSR: 16-bit Galois, polynomial mask 16'hB400, shift right. It steps on every RUN tick. The lane is taken from the pre-step value bits[1:0]: 00→1, 01→2, 10→5, 11→6.
- Spawn: the lowest-index slot with active_mask=0, evaluated before this tick's retirements, receives the state, life←LIFETIME−1, restart pulse, and spawn_count+1. If no slot is free, pulse spawn_missed and leave all slots unchanged.
- Life: each RUN tick, every active slot with life>0 decrements. A slot with life==0 on a tick retires (state 0, mask 0). A slot freed on tick N is spawnable from tick N+1 onward.
- In PAUSE, all counters, the LFSR and all outputs hold.

## Timing
- All outputs are registered. Effects of tick, start and game_over appear on the first clk edge after they are sampled (latency 1).
- star_restart, spawn_missed: high exactly one cycle, aligned with the star_state change.
- Reset (async assert, sync-to-clk release) values:
  - sched_state=IDLE
  - star_state=0, star_restart=0, active_mask=0, spawn_missed=0
  - spawn_count=0
  - LFSR=seed
  - counters=0
- A tick in the same cycle as game_over is ignored.
- A tick in the same cycle as start is not counted; counting begins on the next tick.
- Reset mid-spawn: no restart pulse is emitted after rst falls.

## Structure
- Package star_pkg:
  - star state codes (STAR_HIDE, STAR_UP_A=1, STAR_DOWN_A=2, STAR_DOWN_B=5, STAR_UP_B=6)
  - sched_state encoding
  - lane-mapping function
- Sub-module star_lfsr: seed parameter, step enable, 16-bit value out. Shared later by other random-placement blocks.
- Per-slot life counters and free-slot priority encoder stay inline, generate-loop over NUM_STARS.

## Test plan
- Reset: hold rst=0 with tick toggling. Required: all outputs at their reset values, sched_state=0. After release, with no start, there are no spawns.
- First spawn: start, level=0, then 120 ticks. Required: on the 120th tick, slot 0 restart pulse; star_state[2:0] equals the lane from the model LFSR; spawn_count=1.
- Clamp: level=7. Required: spawns every 30 ticks. level=5 gives 45. Changing 0→7 when ic=100 gives a spawn on the next tick.
- Saturation: NUM_STARS=4, LIFETIME=850, interval 30. Required: the 5th due spawn pulses spawn_missed, mask stays 4'hF. Slot 0 retires on tick 850 after its spawn and is reused on the next due spawn.
- Pause: assert pause for 500 ticks mid-run. Required: state, life, ic, LFSR and outputs unchanged. After release, the spawn schedule resumes shifted exactly 500 ticks.
- game_over/async reset mid-run with 3 active stars. Required: next cycle all star_state=0, sched_state=0, spawn_count kept. rst=0 instead clears spawn_count and the LFSR immediately, without waiting for a clk edge.
